// File: rtl/hdmi_i2c_writer.sv
// Write-only I2C master for the HDMI transmitter: START, addr+W, reg, data, STOP.
// One request per accept; a NACK on any ACK slot ends the frame early with a STOP.
module hdmi_i2c_writer #(
    parameter int CLK_DIV = 125
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       i2c_scl,
    inout  wire        i2c_sda
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [11:0] qcnt;
    logic [1:0]  q;
    logic [4:0]  bit_idx;
    logic [26:0] frame;
    logic        sda_low;
    logic        quarter_end;
    logic        ack_slot;
    logic        frame_bit;

    assign quarter_end = (qcnt == 12'(CLK_DIV - 1));
    assign ack_slot    = (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);
    assign frame_bit   = frame[5'd26 - bit_idx];

    // Open-drain: a 1 is produced only by the external pull-up.
    assign i2c_sda = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clock50) begin
        if (reset) begin
            state     <= S_IDLE;
            qcnt      <= 12'd0;
            q         <= 2'd0;
            bit_idx   <= 5'd0;
            frame     <= 27'd0;
            ack_error <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        frame     <= {dev_addr, 1'b0, 1'b1, reg_addr, 1'b1, reg_data, 1'b1};
                        ack_error <= 1'b0;
                        qcnt      <= 12'd0;
                        q         <= 2'd0;
                        bit_idx   <= 5'd0;
                    end
                end
                S_START, S_BIT, S_STOP: begin
                    if (quarter_end) begin
                        qcnt <= 12'd0;
                        q    <= q + 2'd1;
                    end else begin
                        qcnt <= qcnt + 12'd1;
                    end
                    // Bit index only advances while staying in BIT, so it never leaves 0..26.
                    if (state == S_BIT && quarter_end && q == 2'd3 && state_d == S_BIT)
                        bit_idx <= bit_idx + 5'd1;
                    if (state == S_BIT && quarter_end && q == 2'd2 && ack_slot && i2c_sda == 1'b1)
                        ack_error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state;
        busy    = 1'b0;
        done    = 1'b0;
        i2c_scl = 1'b1;
        sda_low = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_d = S_START;
            end
            S_START: begin
                busy    = 1'b1;
                sda_low = q[1];
                if (quarter_end && q == 2'd3)
                    state_d = S_BIT;
            end
            S_BIT: begin
                busy    = 1'b1;
                i2c_scl = q[1];
                sda_low = ~frame_bit;
                // ack_error was set at the end of q2, so it is already visible in q3.
                if (quarter_end && q == 2'd3 && (ack_error || bit_idx == 5'd26))
                    state_d = S_STOP;
            end
            S_STOP: begin
                busy    = 1'b1;
                i2c_scl = (q != 2'd0);
                sda_low = ~q[1];
                if (quarter_end && q == 2'd3)
                    state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_hdmi_i2c_writer.sv
// Bench for hdmi_i2c_writer: an I2C slave/decoder feeds a scoreboard of expected
// bytes and expected completion records computed from a transaction-level model.
module tb_hdmi_i2c_writer;

    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] dev;
    logic [7:0] rega;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       ack_error;
    logic       scl;
    wire        sda;
    logic       slave_low = 1'b0;
    logic [2:0] ack_mask = 3'b111;

    int checks = 0;
    int errors = 0;

    // {ack_error, byte count, busy cycles}
    logic [7:0]  exp_q[$];
    logic [18:0] exp_done_q[$];

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    hdmi_i2c_writer #(.CLK_DIV(CD)) dut (
        .clock50  (clk),
        .reset    (reset),
        .start    (start),
        .dev_addr (dev),
        .reg_addr (rega),
        .reg_data (data),
        .busy     (busy),
        .done     (done),
        .ack_error(ack_error),
        .i2c_scl  (scl),
        .i2c_sda  (sda)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: bytes go out until the first unacknowledged one (inclusive);
    // each byte costs 9 bits of 4 quarters, plus 4 quarters each for START and STOP.
    task automatic push_expect(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v,
                               input logic [2:0] mask);
        logic [7:0] bytes [3];
        int         nb;
        logic       err;
        bytes[0] = {d, 1'b0};
        bytes[1] = r;
        bytes[2] = v;
        nb  = 3;
        err = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (!mask[k]) begin
                nb  = k + 1;
                err = 1'b1;
            end
        end
        for (int k = 0; k < nb; k++) exp_q.push_back(bytes[k]);
        exp_done_q.push_back({err, 2'(nb), 16'((8 + 36 * nb) * CD)});
    endtask

    // Slave model, bus decoder and scoreboard monitor.
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       cur_scl;
    logic       cur_sda;
    logic [7:0] shreg = 8'd0;
    logic [18:0] e;
    int bit_cnt = 0, byte_cnt = 0, start_cnt = 0, busy_cnt = 0;
    logic stop_seen = 1'b0;

    always @(negedge clk) begin
        cur_scl = scl;
        cur_sda = sda;
        if (reset) begin
            bit_cnt   = 0;
            byte_cnt  = 0;
            start_cnt = 0;
            busy_cnt  = 0;
            stop_seen = 1'b0;
            slave_low = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
                start_cnt++;
                bit_cnt   = 0;
                byte_cnt  = 0;
                stop_seen = 1'b0;
            end
            if (prev_scl && cur_scl && !prev_sda && cur_sda) stop_seen = 1'b1;
            if (!prev_scl && cur_scl) begin
                if (bit_cnt < 8) begin
                    shreg = {shreg[6:0], cur_sda};
                    bit_cnt++;
                end else if (bit_cnt == 8) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected none", shreg);
                    end else begin
                        check("byte", 32'(shreg), 32'(exp_q.pop_front()));
                    end
                    byte_cnt++;
                    bit_cnt = 9;
                end
            end
            if (prev_scl && !cur_scl) begin
                if (bit_cnt == 8 && byte_cnt < 3 && ack_mask[byte_cnt]) begin
                    slave_low = 1'b1;
                end else if (bit_cnt == 9) begin
                    slave_low = 1'b0;
                    bit_cnt   = 0;
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no completion");
                end else begin
                    e = exp_done_q.pop_front();
                    check("ack_error_at_done", 32'(ack_error), 32'(e[18]));
                    check("byte_count", 32'(byte_cnt), 32'(e[17:16]));
                    check("busy_cycles", 32'(busy_cnt), 32'(e[15:0]));
                    check("stop_seen", 32'(stop_seen), 32'd1);
                    check("start_count", 32'(start_cnt), 32'd1);
                    check("busy_in_done", 32'(busy), 32'd0);
                end
                busy_cnt  = 0;
                start_cnt = 0;
            end
        end
        prev_scl = cur_scl;
        prev_sda = cur_sda;
    end

    // Called at a negedge; start is sampled at the following posedge.
    task automatic start_txn(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v,
                             input logic [2:0] mask);
        ack_mask = mask;
        push_expect(d, r, v, mask);
        dev   = d;
        rega  = r;
        data  = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 130 * CD) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
        end
    endtask

    initial begin
        int done_seen;
        reset = 1'b1;
        start = 1'b1;
        dev   = 7'h39;
        rega  = 8'h00;
        data  = 8'h00;

        // Reset held with start asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ack_error", 32'(ack_error), 32'd0);
        check("reset_scl", 32'(scl), 32'd1);
        check("reset_sda", 32'(sda), 32'd1);
        reset = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_after_reset_busy", 32'(busy), 32'd0);
        check("idle_after_reset_scl", 32'(scl), 32'd1);

        // Full write with every slot acknowledged
        start_txn(7'h39, 8'h41, 8'h10, 3'b111);
        wait_done();
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("ack_error_hold_ok", 32'(ack_error), 32'd0);

        // Address NACK
        start_txn(7'h39, 8'h41, 8'h10, 3'b000);
        wait_done();
        @(negedge clk);
        check("ack_error_hold_addr_nack", 32'(ack_error), 32'd1);

        // Data NACK
        start_txn(7'h39, 8'h1a, 8'hc3, 3'b011);
        wait_done();
        @(negedge clk);

        // Ignored mid-transaction start, then back-to-back accept
        start_txn(7'h2a, 8'h5c, 8'ha7, 3'b011);
        repeat (100) @(negedge clk);
        dev   = 7'h11;
        rega  = 8'h22;
        data  = 8'h33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_during_ignored_start", 32'(busy), 32'd1);
        wait_done();
        @(negedge clk);
        check("ack_error_before_b2b", 32'(ack_error), 32'd1);
        start_txn(7'h39, 8'h08, 8'h7e, 3'b111);
        check("ack_error_cleared_on_accept", 32'(ack_error), 32'd0);
        wait_done();
        @(negedge clk);

        // Reset in the middle of bit 12
        start_txn(7'h39, 8'hd6, 8'h04, 3'b111);
        repeat (4 * (4 + 12 * 4) + 2 * CD) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_scl", 32'(scl), 32'd1);
        check("midreset_sda", 32'(sda), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        exp_q.delete();
        exp_done_q.delete();
        reset = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("no_done_after_abort", 32'(done_seen), 32'd0);
        start_txn(7'h39, 8'h55, 8'haa, 3'b111);
        wait_done();
        @(negedge clk);

        // Randomized transactions against the model
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            start_txn(7'($urandom), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            wait_done();
            @(negedge clk);
        end

        check("bytes_left", 32'(exp_q.size()), 32'd0);
        check("dones_left", 32'(exp_done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
